rs_multi_issue: RTL and testbench
=================================

Name: rs_multi_issue

Overview:
Parametrised, multi-dispatch, multi-issue reservation station. It replaces the single-issue shifting queue with a slot array that has CAM-style wakeup and an age matrix for oldest-first selection. It sits between dispatch (writes INST_RS packets) and the functional-unit issue lanes, and snoops NUM_WAKEUP CDB/FU result channels. Freed slots are reused in place (no compaction), and a full flush is supported for branch mispredict recovery.

Parameters:
NUM_ENTRIES, 16, number of RS slots (>=4, power of 2 not required)
DISPATCH_WIDTH, 2, insns accepted per cycle
ISSUE_WIDTH, 2, insns issued per cycle (one per FU lane)
NUM_WAKEUP, 4, wakeup/broadcast channels snooped per cycle
TAG_LEN, `ROB_TAG_LEN, tag width
DATA_LEN, `XLEN, operand width

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
flush  in  1  squash all entries
dispatch_valid  in  [DISPATCH_WIDTH]  lane k carries an insn
dispatch_insn  in  [DISPATCH_WIDTH] INST_RS  insn packet, including tags, ready bits, values and insn_tag
dispatch_ready  out  1  RS can take a full DISPATCH_WIDTH group this cycle
free_count  out  $clog2(NUM_ENTRIES+1)  number of invalid slots
wakeup_valid  in  [NUM_WAKEUP]  broadcast valid
wakeup_tag  in  [NUM_WAKEUP][TAG_LEN]  produced tag
wakeup_value  in  [NUM_WAKEUP][DATA_LEN]  produced value
issue_valid  out  [ISSUE_WIDTH]  lane carries a ready insn
issue_insn  out  [ISSUE_WIDTH] INST_RS  selected insn, with operands filled
issue_ready  in  [ISSUE_WIDTH]  FU lane accepts this cycle

Behaviour:
- State: per-slot valid bit and INST_RS packet; age matrix older[i][j] (1 = slot i older than slot j).
- Reset:
  - All slots invalid; age matrix cleared.
  - Outputs: issue_valid=0, dispatch_ready=1, free_count=NUM_ENTRIES.
- Dispatch:
  - dispatch_ready = (free_count >= DISPATCH_WIDTH), computed from registered state only. Slots freed by issue in the same cycle do not count.
  - Dispatch while dispatch_ready=0 is illegal; assert in simulation.
  - Valid lanes take the lowest-index free slots, lane 0 first; the slot is written at the posedge.
  - The new slot is younger than every slot already valid. Lane k is older than lane k+1.
- Wakeup:
  - Each cycle, every valid slot compares src1/src2 tags against all wakeup channels where the slot's ready bit is 0. On a match, the value is captured and the ready bit set at the posedge.
  - Dispatch bypass: wakeup also applies to packets being dispatched in the same cycle, so no broadcast is lost.
  - Several channels matching one operand in the same cycle is legal only with equal values. The lowest channel index wins.
- Select/issue:
  - Combinational from registered state. A slot is ready when valid & ready_src1 & ready_src2.
  - Lane 0 gets the oldest ready slot. Lane n gets the oldest ready slot not taken by lanes <n.
  - Wakeup in cycle N allows issue no earlier than cycle N+1; there is no same-cycle wakeup-to-issue.
  - Slot freed at the posedge where issue_valid[n] & issue_ready[n].
  - If issue_ready[n]=0, the slot stays valid and may be re-selected next cycle, possibly on another lane if an older slot became ready. Outputs need not be stable under stall.
  - A lane with issue_valid=0 ignores issue_ready.
- Flush: all slots invalid at the next posedge. It overrides same-cycle dispatch and issue acceptance; issue_valid is still driven that cycle, and the FU must ignore it.
- Age-matrix updates on allocate of slot i: older[i][*]=0, then older[j][i]=1 for all j valid or allocated on an earlier lane in the same cycle. No update on free.
- Boundaries:
  - free_count=0: dispatch_ready=0.
  - All slots ready: exactly ISSUE_WIDTH issue per cycle, oldest first.
  - A slot freed and reallocated in the same cycle is not allowed; allocation uses the registered free set.
  - Reset mid-operation drops everything in one cycle.

Decomposition:
- Shared defs (sys_defs.svh / reservation_station.svh): reuse INST_RS; add an RS_SLOT struct (valid, INST_RS); no new constants beyond the parameters.
- Sub-module: rs_age_select. Inputs are the ready vector and the age matrix; outputs are ISSUE_WIDTH one-hot grants, oldest first. It is purely combinational and unit-tested separately.
- Allocation priority encoder and wakeup CAM stay inline.

Test Plan:
- Reset, then dispatch 2 ready insns (tags 5, 6) in cycle 1 -> cycle 2: issue_valid=2'b11, lane0 tag 5, lane1 tag 6; free_count=14 in cycle 2, back to 16 after ack.
- Dispatch insn tag 9 waiting on src1 tag 3, then wakeup tag 3 value 0xDEAD on channel 2 in cycle 4 -> issue_valid[0]=1 in cycle 5 with value_src1=0xDEAD, not in cycle 4.
- Same-cycle bypass: dispatch waiting on tag 7 while wakeup tag 7 value 0x11 fires -> entry ready next cycle, value_src1=0x11.
- Age order: fill 4 slots in order A,B,C,D with D ready first, then A, C ready together -> issue order D, then {A,C} with A on lane 0; after a stall on lane 0 (issue_ready=0), A is re-presented.
- Fill to 15 entries -> dispatch_ready=0; issue one -> dispatch_ready still 0 that cycle and 1 the next.
- Flush with 10 valid slots plus a concurrent dispatch -> next cycle free_count=16, issue_valid=0, dispatched insn dropped.

Source files
------------

// File: rtl/rs_multi_issue_pkg.sv
// Shared types for the multi-issue reservation station: the dispatched
// instruction packet and the per-slot storage record.
package rs_multi_issue_pkg;

  localparam int ROB_TAG_LEN = 6;
  localparam int XLEN        = 32;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] insn_tag;
    logic [ROB_TAG_LEN-1:0] src1_tag;
    logic                   ready_src1;
    logic [XLEN-1:0]        value_src1;
    logic [ROB_TAG_LEN-1:0] src2_tag;
    logic                   ready_src2;
    logic [XLEN-1:0]        value_src2;
  } inst_rs_t;

  typedef struct packed {
    logic     valid;
    inst_rs_t inst;
  } rs_slot_t;

endpackage

// File: rtl/rs_age_select.sv
// Oldest-first multi-grant selector: each lane grants the oldest ready slot
// not already granted to a lower-numbered lane.
module rs_age_select #(
  parameter int NUM_ENTRIES = 16,
  parameter int ISSUE_WIDTH = 2
) (
  input  logic [NUM_ENTRIES-1:0]                        ready,
  input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0]       older,
  output logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0]       grant
);

  logic [NUM_ENTRIES-1:0] remain;
  logic [NUM_ENTRIES-1:0] self_bit;

  // A candidate wins when no other remaining candidate is older than it.
  always_comb begin
    remain   = ready;
    self_bit = '0;
    grant    = '0;
    for (int n = 0; n < ISSUE_WIDTH; n++) begin
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        self_bit    = '0;
        self_bit[j] = 1'b1;
        grant[n][j] = remain[j] & ~(|(remain & ~older[j] & ~self_bit));
      end
      remain = remain & ~grant[n];
    end
  end

endmodule

// File: rtl/rs_multi_issue.sv
// Slot-array reservation station with CAM wakeup (including dispatch bypass),
// age-matrix oldest-first multi-issue and full flush.
module rs_multi_issue
  import rs_multi_issue_pkg::*;
#(
  parameter int NUM_ENTRIES    = 16,
  parameter int DISPATCH_WIDTH = 2,
  parameter int ISSUE_WIDTH    = 2,
  parameter int NUM_WAKEUP     = 4,
  parameter int TAG_LEN        = ROB_TAG_LEN,
  parameter int DATA_LEN       = XLEN
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   flush,
  input  logic [DISPATCH_WIDTH-1:0]              dispatch_valid,
  input  inst_rs_t [DISPATCH_WIDTH-1:0]          dispatch_insn,
  output logic                                   dispatch_ready,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]       free_count,
  input  logic [NUM_WAKEUP-1:0]                  wakeup_valid,
  input  logic [NUM_WAKEUP-1:0][TAG_LEN-1:0]     wakeup_tag,
  input  logic [NUM_WAKEUP-1:0][DATA_LEN-1:0]    wakeup_value,
  output logic [ISSUE_WIDTH-1:0]                 issue_valid,
  output inst_rs_t [ISSUE_WIDTH-1:0]             issue_insn,
  input  logic [ISSUE_WIDTH-1:0]                 issue_ready
);

  localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
  localparam int CNT_W = $clog2(NUM_ENTRIES+1);

  rs_slot_t slot_reg  [NUM_ENTRIES];
  rs_slot_t slot_next [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] older_reg, older_next;

  logic [NUM_ENTRIES-1:0]                   valid_vec, ready_vec, avail;
  logic [ISSUE_WIDTH-1:0][NUM_ENTRIES-1:0]  grant;
  logic [DISPATCH_WIDTH-1:0]                alloc_en;
  logic [DISPATCH_WIDTH-1:0][IDX_W-1:0]     alloc_slot;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_ENTRIES; gi++) begin : g_slot_flags
      assign valid_vec[gi] = slot_reg[gi].valid;
      assign ready_vec[gi] = slot_reg[gi].valid & slot_reg[gi].inst.ready_src1
                           & slot_reg[gi].inst.ready_src2;
    end
  endgenerate

  // Lowest matching channel wins: channels are scanned high to low.
  function automatic inst_rs_t apply_wakeup(input inst_rs_t p);
    inst_rs_t r;
    r = p;
    for (int c = NUM_WAKEUP-1; c >= 0; c--) begin
      if (wakeup_valid[c] && !p.ready_src1 && wakeup_tag[c] == p.src1_tag) begin
        r.ready_src1 = 1'b1;
        r.value_src1 = wakeup_value[c];
      end
      if (wakeup_valid[c] && !p.ready_src2 && wakeup_tag[c] == p.src2_tag) begin
        r.ready_src2 = 1'b1;
        r.value_src2 = wakeup_value[c];
      end
    end
    return r;
  endfunction

  always_comb begin
    free_count = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (!valid_vec[i]) free_count = free_count + CNT_W'(1);
  end

  assign dispatch_ready = (free_count >= CNT_W'(DISPATCH_WIDTH));

  // Allocation only sees the registered free set, so issue-freed slots wait a cycle.
  always_comb begin
    avail      = ~valid_vec;
    alloc_en   = '0;
    alloc_slot = '0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (dispatch_valid[k] && dispatch_ready && !alloc_en[k] && avail[i]) begin
          alloc_en[k]   = 1'b1;
          alloc_slot[k] = IDX_W'(i);
          avail[i]      = 1'b0;
        end
      end
    end
  end

  rs_age_select #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .ISSUE_WIDTH (ISSUE_WIDTH)
  ) u_age_select (
    .ready (ready_vec),
    .older (older_reg),
    .grant (grant)
  );

  always_comb begin
    for (int n = 0; n < ISSUE_WIDTH; n++) begin
      issue_valid[n] = |grant[n];
      issue_insn[n]  = '0;
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (grant[n][i]) issue_insn[n] = slot_reg[i].inst;
    end
  end

  always_comb begin
    slot_next  = slot_reg;
    older_next = older_reg;
    for (int i = 0; i < NUM_ENTRIES; i++)
      slot_next[i].inst = apply_wakeup(slot_reg[i].inst);
    for (int n = 0; n < ISSUE_WIDTH; n++)
      for (int i = 0; i < NUM_ENTRIES; i++)
        if (issue_valid[n] && issue_ready[n] && grant[n][i]) slot_next[i].valid = 1'b0;
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (alloc_en[k]) begin
        slot_next[alloc_slot[k]].valid = 1'b1;
        slot_next[alloc_slot[k]].inst  = apply_wakeup(dispatch_insn[k]);
        older_next[alloc_slot[k]]      = '0;
      end
    end
    // New slots are younger than all resident slots and than earlier lanes.
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      if (alloc_en[k]) begin
        for (int j = 0; j < NUM_ENTRIES; j++)
          if (valid_vec[j]) older_next[j][alloc_slot[k]] = 1'b1;
        for (int m = 0; m < DISPATCH_WIDTH; m++)
          if (m < k && alloc_en[m]) older_next[alloc_slot[m]][alloc_slot[k]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_reg  <= '{default: '0};
      older_reg <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_ENTRIES; i++) slot_reg[i].valid <= 1'b0;
    end else begin
      slot_reg  <= slot_next;
      older_reg <= older_next;
    end
  end

  dispatch_when_full: assert property (@(posedge clk) disable iff (reset)
    (|dispatch_valid) |-> dispatch_ready);

endmodule

// File: tb/tb_rs_multi_issue.sv
// Scoreboard bench for rs_multi_issue: expected issue packets are queued as
// stimulus is driven and compared as the station presents them.
module tb_rs_multi_issue;
  import rs_multi_issue_pkg::*;

  localparam int NE = 16, DW = 2, IW = 2, NW = 4;

  logic clk = 1'b0;
  logic reset, flush;
  logic [DW-1:0] dispatch_valid;
  inst_rs_t [DW-1:0] dispatch_insn;
  logic dispatch_ready;
  logic [4:0] free_count;
  logic [NW-1:0] wakeup_valid;
  logic [NW-1:0][ROB_TAG_LEN-1:0] wakeup_tag;
  logic [NW-1:0][XLEN-1:0] wakeup_value;
  logic [IW-1:0] issue_valid, issue_ready;
  inst_rs_t [IW-1:0] issue_insn;

  typedef struct packed {
    logic [ROB_TAG_LEN-1:0] tag;
    logic [XLEN-1:0]        v1;
    logic [XLEN-1:0]        v2;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rs_multi_issue #(
    .NUM_ENTRIES(NE), .DISPATCH_WIDTH(DW), .ISSUE_WIDTH(IW), .NUM_WAKEUP(NW)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .dispatch_valid(dispatch_valid), .dispatch_insn(dispatch_insn),
    .dispatch_ready(dispatch_ready), .free_count(free_count),
    .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag), .wakeup_value(wakeup_value),
    .issue_valid(issue_valid), .issue_insn(issue_insn), .issue_ready(issue_ready)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic inst_rs_t mk(input int tag, input int t1, input bit r1, input int v1,
                                  input int t2, input bit r2, input int v2);
    inst_rs_t p;
    p.insn_tag   = ROB_TAG_LEN'(tag);
    p.src1_tag   = ROB_TAG_LEN'(t1);
    p.ready_src1 = r1;
    p.value_src1 = XLEN'(v1);
    p.src2_tag   = ROB_TAG_LEN'(t2);
    p.ready_src2 = r2;
    p.value_src2 = XLEN'(v2);
    return p;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = '0;
    dispatch_insn  = '0;
    wakeup_valid   = '0;
    wakeup_tag     = '0;
    wakeup_value   = '0;
    flush          = 1'b0;
  endtask

  task automatic disp(input int lane, input inst_rs_t p);
    dispatch_valid[lane] = 1'b1;
    dispatch_insn[lane]  = p;
  endtask

  task automatic wake(input int ch, input int tag, input int val);
    wakeup_valid[ch] = 1'b1;
    wakeup_tag[ch]   = ROB_TAG_LEN'(tag);
    wakeup_value[ch] = XLEN'(val);
  endtask

  task automatic sb_push(input int tag, input int v1, input int v2);
    exp_t e;
    e.tag = ROB_TAG_LEN'(tag);
    e.v1  = XLEN'(v1);
    e.v2  = XLEN'(v2);
    sb.push_back(e);
  endtask

  // Compare an issue lane with scoreboard entry idx (entry stays queued).
  task automatic sb_check(input int lane, input int idx);
    exp_t e;
    e = (idx < sb.size()) ? sb[idx] : '0;
    check($sformatf("issue_valid[%0d]", lane), 64'(issue_valid[lane]), 64'(1));
    check($sformatf("tag[%0d]", lane), 64'(issue_insn[lane].insn_tag), 64'(e.tag));
    check($sformatf("src1[%0d]", lane), 64'(issue_insn[lane].value_src1), 64'(e.v1));
    check($sformatf("src2[%0d]", lane), 64'(issue_insn[lane].value_src2), 64'(e.v2));
  endtask

  always @(negedge clk) begin
    for (int n = 0; n < IW; n++)
      if (!reset && !flush && issue_valid[n] && issue_ready[n])
        $display("issue lane %0d tag %0d src1 %0h src2 %0h", n,
                 issue_insn[n].insn_tag, issue_insn[n].value_src1, issue_insn[n].value_src2);
    for (int k = 0; k < DW; k++)
      if (!reset && dispatch_valid[k])
        $display("dispatch lane %0d tag %0d flush %0b", k, dispatch_insn[k].insn_tag, flush);
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    issue_ready = '0;
    idle();
    repeat (3) cyc();
    check("rst_issue_valid", 64'(issue_valid), 64'(0));
    check("rst_dispatch_ready", 64'(dispatch_ready), 64'(1));
    check("rst_free_count", 64'(free_count), 64'(16));
    reset = 1'b0;

    // Two ready insns issue together, oldest (lane 0) first.
    disp(0, mk(5, 0, 1, 'h105, 0, 1, 'h205));
    disp(1, mk(6, 0, 1, 'h106, 0, 1, 'h206));
    sb_push(5, 'h105, 'h205);
    sb_push(6, 'h106, 'h206);
    cyc(); idle();
    check("t1_free", 64'(free_count), 64'(14));
    sb_check(0, 0);
    sb_check(1, 1);
    issue_ready = 2'b11;
    cyc(); void'(sb.pop_front()); void'(sb.pop_front());
    issue_ready = 2'b00;
    check("t1_free_after", 64'(free_count), 64'(16));
    check("t1_empty", 64'(issue_valid), 64'(0));

    // Wakeup on channel 2 enables issue only the following cycle.
    disp(0, mk(9, 3, 0, 0, 0, 1, 'h99));
    sb_push(9, 'hDEAD, 'h99);
    cyc(); idle();
    check("t2_waiting", 64'(issue_valid), 64'(0));
    wake(0, 4, 'hBAD);
    wake(2, 3, 'hDEAD);
    check("t2_no_same_cycle", 64'(issue_valid), 64'(0));
    cyc(); idle();
    sb_check(0, 0);
    check("t2_lane1_idle", 64'(issue_valid[1]), 64'(0));
    issue_ready = 2'b01;
    cyc(); void'(sb.pop_front());
    issue_ready = 2'b00;

    // Wakeup concurrent with dispatch is captured by the bypass path.
    disp(0, mk(10, 7, 0, 0, 8, 0, 0));
    wake(1, 7, 'h11);
    wake(3, 8, 'h22);
    sb_push(10, 'h11, 'h22);
    cyc(); idle();
    sb_check(0, 0);
    issue_ready = 2'b01;
    cyc(); void'(sb.pop_front());
    issue_ready = 2'b00;

    // Age order independent of slot index: C,D land in lower slots than A,B.
    sb_push(11, 'h30, 0);
    sb_push(12, 'h30, 0);
    sb_push(16, 'h222, 0);
    sb_push(13, 'h20, 0);
    sb_push(15, 'h20, 0);
    sb_push(14, 'h21, 0);
    disp(0, mk(11, 30, 0, 0, 0, 1, 0));
    disp(1, mk(12, 30, 0, 0, 0, 1, 0));
    cyc(); idle();
    disp(0, mk(13, 20, 0, 0, 0, 1, 0));
    disp(1, mk(14, 21, 0, 0, 0, 1, 0));
    cyc(); idle();
    check("t4_none_ready", 64'(issue_valid), 64'(0));
    wake(0, 30, 'h30);
    cyc(); idle();
    sb_check(0, 0);
    sb_check(1, 1);
    issue_ready = 2'b11;
    cyc(); void'(sb.pop_front()); void'(sb.pop_front());
    issue_ready = 2'b00;
    disp(0, mk(15, 20, 0, 0, 0, 1, 0));
    disp(1, mk(16, 22, 0, 0, 0, 1, 0));
    cyc(); idle();
    check("t4_free", 64'(free_count), 64'(12));
    wake(1, 22, 'h222);
    cyc(); idle();
    sb_check(0, 0);
    check("t4_d_alone", 64'(issue_valid[1]), 64'(0));
    issue_ready = 2'b11;
    wake(2, 20, 'h20);
    cyc(); idle(); void'(sb.pop_front());
    sb_check(0, 0);
    sb_check(1, 1);
    issue_ready = 2'b10;
    cyc(); sb.delete(1);
    sb_check(0, 0);
    check("t4_stall_lane1_idle", 64'(issue_valid[1]), 64'(0));
    issue_ready = 2'b01;
    cyc(); void'(sb.pop_front());
    issue_ready = 2'b00;
    wake(0, 21, 'h21);
    cyc(); idle();
    sb_check(0, 0);
    issue_ready = 2'b01;
    cyc(); void'(sb.pop_front());
    issue_ready = 2'b00;
    check("t4_free_after", 64'(free_count), 64'(16));

    // Fill to 15: dispatch_ready drops, recovers one cycle after an issue.
    for (int c = 0; c < 7; c++) begin
      disp(0, mk(20 + 2*c, 40, 0, 0, 0, 1, 0));
      disp(1, mk(21 + 2*c, 40, 0, 0, 0, 1, 0));
      cyc(); idle();
    end
    check("t5_free14", 64'(free_count), 64'(2));
    check("t5_ready14", 64'(dispatch_ready), 64'(1));
    disp(0, mk(50, 0, 1, 'h50, 0, 1, 'h55));
    sb_push(50, 'h50, 'h55);
    cyc(); idle();
    check("t5_free15", 64'(free_count), 64'(1));
    check("t5_not_ready", 64'(dispatch_ready), 64'(0));
    sb_check(0, 0);
    issue_ready = 2'b01;
    check("t5_not_ready_same_cycle", 64'(dispatch_ready), 64'(0));
    cyc(); void'(sb.pop_front());
    issue_ready = 2'b00;
    check("t5_ready_again", 64'(dispatch_ready), 64'(1));
    check("t5_free_again", 64'(free_count), 64'(2));
    flush = 1'b1;
    cyc(); idle();
    check("t5_flushed", 64'(free_count), 64'(16));

    // Flush with 10 valid slots overrides concurrent dispatch and issue ack.
    for (int c = 0; c < 5; c++) begin
      disp(0, mk(30 + 2*c, 41, 0, 0, 0, 1, 0));
      if (c == 4) disp(1, mk(60, 0, 1, 'h60, 0, 1, 'h66));
      else        disp(1, mk(31 + 2*c, 41, 0, 0, 0, 1, 0));
      cyc(); idle();
    end
    sb_push(60, 'h60, 'h66);
    check("t6_free10", 64'(free_count), 64'(6));
    sb_check(0, 0);
    flush = 1'b1;
    disp(0, mk(61, 0, 1, 'h61, 0, 1, 'h61));
    issue_ready = 2'b11;
    check("t6_issue_during_flush", 64'(issue_valid[0]), 64'(1));
    cyc(); idle(); void'(sb.pop_front());
    issue_ready = 2'b00;
    check("t6_free_after_flush", 64'(free_count), 64'(16));
    check("t6_dropped", 64'(issue_valid), 64'(0));

    // Reset mid-operation empties the station in one cycle.
    disp(0, mk(1, 0, 1, 1, 0, 1, 1));
    disp(1, mk(2, 41, 0, 0, 0, 1, 2));
    cyc(); idle();
    check("t7_before_reset", 64'(free_count), 64'(14));
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("t7_reset_free", 64'(free_count), 64'(16));
    check("t7_reset_issue", 64'(issue_valid), 64'(0));
    check("t7_sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
